// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter owning the register-file write port
//
// Purpose: merges ALU results (buffered in a DEPTH-entry FIFO) and LSU load
// results into one registered register-file write per cycle, and keeps a
// per-register pending scoreboard so decode can stall on RAW/WAW hazards.
//
// Ports:
//   clk, rst                    clock, synchronous active-low reset
//   alu_valid/alu_ready         ALU result handshake (FIFO push)
//   alu_rd, alu_data            ALU destination register and result
//   lsu_valid/lsu_ready         LSU result handshake (accepted this cycle)
//   lsu_rd, lsu_data            load destination register and data
//   iss_valid, iss_rd           issued instruction with a destination
//   q_rs1, q_rs2, q_rd, stall   decode hazard query and its answer
//   wen, rd, result             registered register-file write

module wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int NREG  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  input  logic [4:0]      q_rs1,
  input  logic [4:0]      q_rs2,
  input  logic [4:0]      q_rd,
  output logic            stall,
  output logic            wen,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] result
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [4:0]      fifo_rd   [DEPTH];
  logic [XLEN-1:0] fifo_data [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [CW-1:0]   count;
  logic [NREG-1:0] pend, pend_next;

  logic            full, nonempty, push, pop, win, win_wr;
  logic [4:0]      win_rd;
  logic [XLEN-1:0] win_data;

  assign full     = (count == FULL_CNT);
  assign nonempty = (count != '0);

  // Ready is derived from the pre-pop count, so a full FIFO never takes a
  // push even in the cycle it pops.
  assign alu_ready = rst && !full;
  assign push      = alu_valid && alu_ready;

  // A full FIFO outranks the LSU so ALU results cannot be starved forever.
  always_comb begin
    lsu_ready = 1'b0;
    pop       = 1'b0;
    win       = 1'b0;
    win_rd    = '0;
    win_data  = '0;
    if (rst) begin
      if (full) begin
        pop      = 1'b1;
        win      = 1'b1;
        win_rd   = fifo_rd[rptr];
        win_data = fifo_data[rptr];
      end else begin
        lsu_ready = 1'b1;
        if (lsu_valid) begin
          win      = 1'b1;
          win_rd   = lsu_rd;
          win_data = lsu_data;
        end else if (nonempty) begin
          pop      = 1'b1;
          win      = 1'b1;
          win_rd   = fifo_rd[rptr];
          win_data = fifo_data[rptr];
        end
      end
    end
  end

  // Writes to x0 are consumed but never reach the register file.
  assign win_wr = win && (win_rd != 5'd0);

  // Clear on the write, then set, so a same-edge re-issue stays pending.
  always_comb begin
    pend_next = pend;
    if (win_wr) begin
      pend_next[win_rd] = 1'b0;
    end
    if (iss_valid && (iss_rd != 5'd0)) begin
      pend_next[iss_rd] = 1'b1;
    end
    pend_next[0] = 1'b0;
  end

  assign stall = ((q_rs1 != 5'd0) && pend[q_rs1]) |
                 ((q_rs2 != 5'd0) && pend[q_rs2]) |
                 ((q_rd  != 5'd0) && pend[q_rd]);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wptr]   <= alu_rd;
      fifo_data[wptr] <= alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wen    <= 1'b0;
      rd     <= '0;
      result <= '0;
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      pend   <= '0;
    end else begin
      wen <= win_wr;
      if (win_wr) begin
        rd     <= win_rd;
        result <= win_data;
      end
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      pend <= pend_next;
    end
  end

endmodule
